// File: rtl/vect_gather_pkg.sv
// vt_pkg: shared types and helpers for the vect_gather receive block.
// Holds the collect/hold state encoding, the beats-per-vector helper,
// the exponent-field extractor and the V/P divisibility check used at
// elaboration time.
package vt_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Number of P-lane beats that make up one V-lane vector.
  function automatic int beats(input int v, input int p);
    return v / p;
  endfunction

  // True when V is an integer multiple of P.
  function automatic bit vp_ok(input int v, input int p);
    return (p > 0) && ((v % p) == 0);
  endfunction

  // Biased exponent field of a lane: bits [bitw-2 -: expw].
  // Lanes are zero-extended to 64 bits so one helper serves any lane width.
  function automatic logic [63:0] exp_of(input logic [63:0] lane,
                                         input int          bitw,
                                         input int          expw);
    return (lane >> (bitw - 1 - expw)) & ((64'd1 << expw) - 64'd1);
  endfunction

endpackage

// File: rtl/vect_gather_exp_max_p.sv
// exp_max_p: combinational maximum of the exponent fields across the
// P lanes of one beat. Fields are compared as unsigned biased values.
module exp_max_p
  import vt_pkg::*;
#(
  parameter int P    = 4,
  parameter int BIT  = 32,
  parameter int EXPW = 8
) (
  input  logic [P-1:0][BIT-1:0] lanes,
  output logic [EXPW-1:0]       max_exp
);

  logic [EXPW-1:0] cur;

  // Running unsigned max over the lanes; zero is the identity.
  always_comb begin
    cur     = '0;
    max_exp = '0;
    for (int j = 0; j < P; j++) begin
      cur = EXPW'(exp_of(64'(lanes[j]), BIT, EXPW));
      if (cur > max_exp) max_exp = cur;
    end
  end

endmodule

// File: rtl/vect_gather.sv
// vect_gather: reassembles a stream of P-lane beats into one V-lane
// vector and holds it for the downstream stage until acknowledged.
// Optional block-exponent tracking is enabled with the BLOCK_EXP_EN macro.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   COLLECT | accepting beats; lane group cnt is written on each beat
//   HOLD    | vector complete and held; waits for vector_ack
module vect_gather
  import vt_pkg::*;
#(
  parameter int V    = 8,
  parameter int P    = 4,
  parameter int BIT  = 32,
  parameter int EXPW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [P-1:0][BIT-1:0] invals,
  input  logic                  done_in,
  output logic                  in_rdy,
  output logic                  vector_rdy,
  output logic [V-1:0][BIT-1:0] vector,
  output logic                  short,
  input  logic                  vector_ack
`ifdef BLOCK_EXP_EN
  ,
  output logic [EXPW-1:0]       block_exp
`endif
);

  localparam int BEATS = beats(V, P);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!vp_ok(V, P)) begin : g_bad_vp
    $error("vect_gather: V must be an integer multiple of P");
  end

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [V-1:0][BIT-1:0]   vector_q, vector_d;
  logic                    short_q, short_d;
  logic                    accept;
  logic                    last_beat;

  assign in_rdy     = (state_q == COLLECT) && !reset;
  assign vector_rdy = (state_q == HOLD);
  assign vector     = vector_q;
  assign short      = short_q;
  assign accept     = valid_in && in_rdy;
  assign last_beat  = (cnt_q == CW'(BEATS - 1));

  // Next-state, beat placement and early-close detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vector_d = vector_q;
    short_d  = short_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CW'(b)) begin
              for (int j = 0; j < P; j++) vector_d[b*P+j] = invals[j];
            end
          end
          if (last_beat || done_in) begin
            state_d = HOLD;
            short_d = !last_beat;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Clearing here keeps unwritten lanes of the next short vector at 0.
        if (vector_ack) begin
          state_d  = COLLECT;
          cnt_d    = '0;
          vector_d = '0;
          short_d  = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State, beat counter and vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      vector_q <= '0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vector_q <= vector_d;
      short_q  <= short_d;
    end
  end

`ifdef BLOCK_EXP_EN
  logic [EXPW-1:0] block_exp_q, block_exp_d;
  logic [EXPW-1:0] beat_exp;

  exp_max_p #(
    .P    (P),
    .BIT  (BIT),
    .EXPW (EXPW)
  ) u_exp_max (
    .lanes   (invals),
    .max_exp (beat_exp)
  );

  // Fold each accepted beat's max exponent in; clear on handoff.
  always_comb begin
    block_exp_d = block_exp_q;
    if (accept && (beat_exp > block_exp_q)) block_exp_d = beat_exp;
    if ((state_q == HOLD) && vector_ack)    block_exp_d = '0;
  end

  // Block exponent register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) block_exp_q <= '0;
    else       block_exp_q <= block_exp_d;
  end

  assign block_exp = block_exp_q;
`endif

endmodule

// File: doc/vect_gather.md
Name: vect_gather

Overview:
- Receive-side counterpart of the vector transmitter. Accepts a stream of P-lane floating-point beats and reassembles them into one V-lane vector.
- Presents the full vector with a ready/ack handshake to the downstream dot-product block-floating-point stage.
- Optionally tracks the block (maximum) exponent across the assembled vector.

Parameters:
- V, 8, number of lanes in the assembled vector; must be an integer multiple of P
- P, 4, lanes per input beat
- BIT, 32, width of each lane (IEEE-754 single by default)
- EXPW, 8, exponent field width; field is lane bits [BIT-2 -: EXPW]

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  a beat is present on invals this cycle
- invals  in  [P-1:0][BIT-1:0]  beat lanes
- done_in  in  1  qualifies valid_in; this beat is the last of the current vector
- in_rdy  out  1  block can accept a beat this cycle
- vector_rdy  out  1  assembled vector is valid and held
- vector  out  [V-1:0][BIT-1:0]  assembled vector
- short  out  1  vector was closed by done_in before BEATS beats arrived
- vector_ack  in  1  consumer takes the vector; honoured only while vector_rdy=1
- block_exp  out  EXPW  max exponent field over the vector (only with BLOCK_EXP_EN)

Behaviour:
- BEATS = V/P. Beat counter cnt has width $clog2(BEATS), minimum 1.
- Two states:
  - COLLECT: in_rdy=1, vector_rdy=0.
  - HOLD: in_rdy=0, vector_rdy=1.
- Reset (synchronous, while reset=1):
  - state goes to COLLECT, cnt=0.
  - vector, vector_rdy, short and block_exp are all 0.
  - in_rdy=0 while reset is asserted; in_rdy=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards any partial or held vector with no output.
- COLLECT, beat accepted (valid_in & in_rdy):
  - Lane j of the beat is written to vector[cnt*P+j], so beat 0 fills lanes 0..P-1, matching transmitter order.
  - If cnt==BEATS-1 or done_in=1: move to HOLD.
  - Otherwise cnt increments.
- Early close: if done_in closes the vector with cnt<BEATS-1, the unwritten lanes stay 0 and short=1. Otherwise short=0.
- Latency: vector_rdy rises in the cycle after the final beat is accepted.
- done_in with valid_in=0 is ignored.
- HOLD:
  - vector, short and block_exp are stable.
  - valid_in is ignored (no capture, no error).
  - On vector_ack=1: go to COLLECT next cycle, cnt=0, all lanes cleared to 0, short=0, block_exp=0; vector_rdy falls in that same next cycle.
  - No same-cycle pass-through: a beat offered in the ack cycle is not accepted and is seen only by the next COLLECT cycle.
- vector_ack in COLLECT has no effect.
- Throughput: one vector per BEATS+1 cycles minimum when vector_ack is held high.
- Lane contents are treated as opaque bits. No arithmetic on lanes except exponent extraction.

Optional Feature:
- Macro BLOCK_EXP_EN.
- When defined:
  - block_exp port exists.
  - Per accepted beat, block_exp <= max(block_exp, max over j of exp(invals[j])), compared unsigned on the biased field.
  - The value is final when vector_rdy rises and is held through HOLD.
  - Zero-filled lanes of a short vector do not contribute; 0 is the identity.
- When undefined: the block_exp port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vt_pkg holds:
  - state enum type (COLLECT, HOLD)
  - function beats(V,P)
  - function exp_of(lane) returning bits [BIT-2 -: EXPW]
  - elaboration-time check that V % P == 0
- One sub-module, exp_max_p: combinational P-lane max of exponent fields. It is instantiated only under BLOCK_EXP_EN.

Test Plan:
1. Reset, then 2 beats {3FC00000,3FE00000,3FF00000,3FF80000}, each repeated once, done_in on beat 2 -> vector_rdy the cycle after beat 2; vector[0..7] = 3FC00000,3FE00000,3FF00000,3FF80000 repeated; short=0; block_exp=0x7F.
2. Same but beat 2 lane 3 = 40800000 (4.0) -> vector[7]=40800000, block_exp=0x81.
3. Single beat with done_in=1 -> short=1, vector[4..7]=0, vector_rdy=1 the next cycle.
4. Hold vector_ack=0 for 5 cycles while driving valid_in with new data -> vector unchanged, in_rdy=0 throughout; then ack -> vector_rdy=0 and in_rdy=1 the next cycle, lanes cleared to 0.
5. Assert reset after beat 1 of 2 -> next cycle all outputs 0; a fresh 2-beat vector then assembles correctly from lane 0.
6. Continuous back-to-back vectors with vector_ack tied to 1 -> a new vector_rdy pulse every 3 cycles with correct lane data each time.
